// File: rtl/unified_cache_miss_replay_queue_pkg.sv
// Shared packet layout constants and entry-state encoding for the miss replay queue.
package unified_cache_miss_replay_queue_pkg;

  localparam int unsigned UC_PACKET_WIDTH_IN_BITS = 64;
  localparam int unsigned UC_PACKET_ADDR_POS_LO   = 0;
  localparam int unsigned UC_PACKET_ADDR_POS_HI   = 31;
  localparam int unsigned UC_PACKET_VALID_POS     = 63;
  localparam int unsigned UC_BLOCK_SIZE_IN_BYTES  = 64;

  typedef enum logic [1:0] {
    ENTRY_INVALID    = 2'd0,
    ENTRY_WAIT_ISSUE = 2'd1,
    ENTRY_WAIT_FILL  = 2'd2,
    ENTRY_READY      = 2'd3
  } entry_state_e;

endpackage

// File: rtl/unified_cache_miss_replay_queue_find_first_one_index.sv
// Lowest-index set-bit finder; reports whether any bit is set and its index.
module find_first_one_index #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vector_in,
  output logic             found_out,
  output logic [IDX_W-1:0] index_out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_out = 1'b0;
    index_out = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vector_in[i]) begin
        found_out = 1'b1;
        index_out = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/unified_cache_miss_replay_queue.sv
// Per-bank miss holding queue: one memory miss per distinct block, parked
// requests replayed into the arbiter once their block has been filled.
module unified_cache_miss_replay_queue
  import unified_cache_miss_replay_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRY                          = 4,
  parameter int unsigned UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = UC_PACKET_WIDTH_IN_BITS,
  parameter int unsigned BLOCK_SIZE_IN_BYTES                = UC_BLOCK_SIZE_IN_BYTES
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] miss_request_in,
  input  logic                                          miss_request_valid_in,
  output logic                                          miss_enqueue_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] memory_miss_out,
  output logic                                          memory_miss_valid_out,
  input  logic                                          memory_miss_ack_in,
  input  logic                                          fill_done_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] fill_packet_in,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] replay_request_out,
  input  logic                                          replay_request_ack_in,
  output logic                                          is_full_out
);

  localparam int unsigned W        = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int unsigned IDX_W    = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE_IN_BYTES);
  localparam int unsigned BLK_LO   = UC_PACKET_ADDR_POS_LO + OFFSET_W;
  localparam int unsigned BLK_W    = UC_PACKET_ADDR_POS_HI - BLK_LO + 1;

  function automatic logic [BLK_W-1:0] block_of(input logic [W-1:0] pkt);
    return pkt[UC_PACKET_ADDR_POS_HI:BLK_LO];
  endfunction

  entry_state_e   state_q   [NUM_ENTRY];
  entry_state_e   state_d   [NUM_ENTRY];
  logic [W-1:0]   payload_q [NUM_ENTRY];
  logic [W-1:0]   payload_d [NUM_ENTRY];

  logic [NUM_ENTRY-1:0] invalid_vec;
  logic [NUM_ENTRY-1:0] wait_issue_vec;
  logic [NUM_ENTRY-1:0] ready_vec;
  logic [NUM_ENTRY-1:0] fill_hit_vec;
  logic [NUM_ENTRY-1:0] same_block_pending_vec;

  logic             alloc_found, issue_found, replay_found;
  logic [IDX_W-1:0] alloc_idx, issue_idx, replay_idx;
  logic             enqueue_fire, issue_fire, replay_fire;
  logic             enqueue_fill_hit;
  logic [W-1:0]     replay_pkt;

  // Only the block-address field of the fill packet is consulted.
  logic             unused_fill_pkt;
  assign unused_fill_pkt = ^fill_packet_in;

  // Per-entry status vectors and address matches against fill and incoming miss.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      invalid_vec[i]            = (state_q[i] == ENTRY_INVALID);
      wait_issue_vec[i]         = (state_q[i] == ENTRY_WAIT_ISSUE);
      ready_vec[i]              = (state_q[i] == ENTRY_READY);
      fill_hit_vec[i]           = fill_done_in
                                  && ((state_q[i] == ENTRY_WAIT_ISSUE) || (state_q[i] == ENTRY_WAIT_FILL))
                                  && (block_of(payload_q[i]) == block_of(fill_packet_in));
      same_block_pending_vec[i] = ((state_q[i] == ENTRY_WAIT_ISSUE) || (state_q[i] == ENTRY_WAIT_FILL))
                                  && (block_of(payload_q[i]) == block_of(miss_request_in));
    end
  end

  find_first_one_index #(.WIDTH(NUM_ENTRY)) u_alloc_finder (
    .vector_in (invalid_vec),
    .found_out (alloc_found),
    .index_out (alloc_idx)
  );

  find_first_one_index #(.WIDTH(NUM_ENTRY)) u_issue_finder (
    .vector_in (wait_issue_vec),
    .found_out (issue_found),
    .index_out (issue_idx)
  );

  find_first_one_index #(.WIDTH(NUM_ENTRY)) u_replay_finder (
    .vector_in (ready_vec),
    .found_out (replay_found),
    .index_out (replay_idx)
  );

  assign is_full_out           = ~alloc_found;
  assign miss_enqueue_ack_out  = miss_request_valid_in && alloc_found;
  assign memory_miss_valid_out = issue_found;
  assign memory_miss_out       = issue_found ? payload_q[issue_idx] : '0;

  assign enqueue_fire     = miss_enqueue_ack_out;
  assign issue_fire       = issue_found && memory_miss_ack_in;
  assign replay_fire      = replay_found && replay_request_ack_in;
  assign enqueue_fill_hit = fill_done_in && (block_of(miss_request_in) == block_of(fill_packet_in));

  // Replay packet carries its valid in-band; all zeros when nothing is ready.
  always_comb begin
    replay_pkt = '0;
    if (replay_found) begin
      replay_pkt                      = payload_q[replay_idx];
      replay_pkt[UC_PACKET_VALID_POS] = 1'b1;
    end
  end
  assign replay_request_out = replay_pkt;

  // Next-state: issue, then fill (fill overrides issue), replay-free, enqueue.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      state_d[i]   = state_q[i];
      payload_d[i] = payload_q[i];
    end
    if (issue_fire) begin
      state_d[issue_idx] = ENTRY_WAIT_FILL;
    end
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (fill_hit_vec[i]) begin
        state_d[i] = ENTRY_READY;
      end
    end
    if (replay_fire) begin
      state_d[replay_idx] = ENTRY_INVALID;
    end
    if (enqueue_fire) begin
      payload_d[alloc_idx] = miss_request_in;
      if (enqueue_fill_hit) begin
        state_d[alloc_idx] = ENTRY_READY;
      end else if (|same_block_pending_vec) begin
        state_d[alloc_idx] = ENTRY_WAIT_FILL;
      end else begin
        state_d[alloc_idx] = ENTRY_WAIT_ISSUE;
      end
    end
  end

  // Entry state and payload registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (!reset_in) begin
        state_q[i]   <= ENTRY_INVALID;
        payload_q[i] <= '0;
      end else begin
        state_q[i]   <= state_d[i];
        payload_q[i] <= payload_d[i];
      end
    end
  end

endmodule
